// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state codes, oversample
// ratio and the baud-tick divisor rounding helper.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_DATA     = 3'd2;
    localparam logic [2:0] ST_PARITY   = 3'd3;
    localparam logic [2:0] ST_STOP     = 3'd4;
    localparam logic [2:0] ST_ERR_WAIT = 3'd5;

    // Nearest-integer clocks per oversample tick.
    function automatic int unsigned os_divisor(input int unsigned clock_rate,
                                               input int unsigned baud_rate);
        return (clock_rate + (baud_rate * OVERSAMPLE) / 2) / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/meta_harden.sv
// Two-flop synchronizer for an asynchronous level; both stages reset to 1
// so an idle serial line is seen as idle straight out of reset.
module meta_harden (
    input  logic clk_dst,
    input  logic rst_dst_n,
    input  logic signal_src,
    output logic signal_dst
);

    logic signal_meta;

    always_ff @(posedge clk_dst or negedge rst_dst_n) begin
        if (!rst_dst_n) begin
            signal_meta <= 1'b1;
            signal_dst  <= 1'b1;
        end else begin
            signal_meta <= signal_src;
            signal_dst  <= signal_meta;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// 16x oversampled UART receiver (8 data bits LSB first, 1 stop bit).
// Define UART_RX_PARITY_EN to expect one even-parity bit before STOP.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 50_000_000,
    parameter int unsigned BAUD_RATE  = 57_600
) (
    input  logic       clk_rx,
    input  logic       rst_clk_rx,
    input  logic       rxd_i,
    output logic [7:0] rx_data,
    output logic       rx_data_rdy,
    output logic       frm_err,
    output logic       par_err
);

    localparam int unsigned OS_DIV = os_divisor(CLOCK_RATE, BAUD_RATE);
    localparam int unsigned DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);

    logic             rx_sync;
    logic [2:0]       state;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       os_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       data_sr;

    meta_harden u_meta_harden (
        .clk_dst    (clk_rx),
        .rst_dst_n  (rst_clk_rx),
        .signal_src (rxd_i),
        .signal_dst (rx_sync)
    );

    assign tick = (div_cnt == DIV_LAST);

    // Held at zero in IDLE so the sample phase is referenced to the start edge.
    always_ff @(posedge clk_rx or negedge rst_clk_rx) begin
        if (!rst_clk_rx) begin
            div_cnt <= '0;
        end else if (state == ST_IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_err_r;
    assign par_err = par_err_r;
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk_rx or negedge rst_clk_rx) begin
        if (!rst_clk_rx) begin
            state       <= ST_IDLE;
            os_cnt      <= '0;
            bit_cnt     <= '0;
            data_sr     <= '0;
            rx_data     <= '0;
            rx_data_rdy <= 1'b0;
            frm_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            par_err_r   <= 1'b0;
`endif
        end else begin
            rx_data_rdy <= 1'b0;
            frm_err     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_r   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    os_cnt  <= '0;
                    bit_cnt <= '0;
                    if (!rx_sync) state <= ST_START;
                end
                ST_START: begin
                    if (tick) begin
                        if (os_cnt == 4'd7) begin
                            os_cnt <= '0;
                            state  <= rx_sync ? ST_IDLE : ST_DATA;
                        end else begin
                            os_cnt <= os_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        os_cnt <= os_cnt + 1'b1;
                        if (os_cnt == 4'd15) begin
                            data_sr[bit_cnt] <= rx_sync;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                                state   <= ST_PARITY;
`else
                                state   <= ST_STOP;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        os_cnt <= os_cnt + 1'b1;
                        if (os_cnt == 4'd15) begin
                            par_bad <= rx_sync ^ (^data_sr);
                            state   <= ST_STOP;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        os_cnt <= os_cnt + 1'b1;
                        if (os_cnt == 4'd15) begin
                            if (rx_sync) begin
                                rx_data     <= data_sr;
                                rx_data_rdy <= 1'b1;
`ifdef UART_RX_PARITY_EN
                                par_err_r   <= par_bad;
`endif
                                state       <= ST_IDLE;
                            end else begin
                                frm_err <= 1'b1;
                                state   <= ST_ERR_WAIT;
                            end
                        end
                    end
                end
                ST_ERR_WAIT: begin
                    if (rx_sync) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed/randomized bench for uart_rx_sampler at 50 MHz / 57600 baud.
// Honours UART_RX_PARITY_EN to match the DUT build.
module tb_uart_rx_sampler;

    localparam int unsigned BIT_NS = 17361;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned NBITS = 10;
`else
    localparam int unsigned NBITS = 9;
`endif
    localparam int unsigned LAT = 2 + (8 + 16 * NBITS) * 54 + 1;

    logic       clk_rx     = 1'b0;
    logic       rst_clk_rx = 1'b0;
    logic       rxd_i      = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       frm_err;
    logic       par_err;

    uart_rx_sampler #(
        .CLOCK_RATE (50_000_000),
        .BAUD_RATE  (57_600)
    ) dut (
        .clk_rx      (clk_rx),
        .rst_clk_rx  (rst_clk_rx),
        .rxd_i       (rxd_i),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .frm_err     (frm_err),
        .par_err     (par_err)
    );

    always #10 clk_rx = ~clk_rx;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } evt_t;

    evt_t        obs_q[$];
    evt_t        exp_q[$];
    int unsigned cyc = 0;
    int unsigned rdy_cyc = 0;
    int unsigned frm_obs = 0;
    int unsigned overlap = 0;
    int unsigned stray_perr = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  last_good = 8'h00;

    always @(posedge clk_rx) cyc <= cyc + 1;

    always @(negedge clk_rx) begin
        if (rx_data_rdy) begin
            obs_q.push_back('{data: rx_data, perr: par_err});
            rdy_cyc = cyc;
        end
        if (frm_err) frm_obs++;
        if (rx_data_rdy && frm_err) overlap++;
        if (par_err && !rx_data_rdy) stray_perr++;
    end

    function automatic logic even_par(input logic [7:0] d);
        int unsigned ones = 0;
        for (int i = 0; i < 8; i++) ones += d[i];
        return (ones % 2) == 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the line at the stop-bit level when it returns.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        rxd_i = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 8; i++) begin
            rxd_i = d[i];
            #(BIT_NS);
        end
`ifdef UART_RX_PARITY_EN
        rxd_i = par;
        #(BIT_NS);
`else
        if (par) begin end
`endif
        rxd_i = stop;
        #(BIT_NS);
    endtask

    task automatic send_good(input logic [7:0] d);
        exp_q.push_back('{data: d, perr: 1'b0});
        last_good = d;
        send_frame(d, 1'b1, even_par(d));
    endtask

    task automatic compare_frames(input string tag);
        evt_t o, e;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : '{data: 8'hxx, perr: 1'bx};
            check({tag, "_data"}, {24'h0, o.data}, {24'h0, e.data});
            check({tag, "_perr"}, {31'h0, o.perr}, {31'h0, e.perr});
        end
        obs_q.delete();
    endtask

    initial begin
        int unsigned fall_cyc;
        logic [7:0] rnd;

        #50;
        check("rst_rx_data", {24'h0, rx_data}, 32'h0);
        check("rst_rdy", {31'h0, rx_data_rdy}, 32'h0);
        check("rst_frm", {31'h0, frm_err}, 32'h0);
        check("rst_perr", {31'h0, par_err}, 32'h0);
        #55;
        rst_clk_rx = 1'b1;
        #2000;

        // Single 0xA5 with latency measured from the falling start edge.
        @(posedge clk_rx);
        #2;
        fall_cyc = cyc;
        send_good(8'hA5);
        #(BIT_NS);
        check("a5_latency", rdy_cyc - fall_cyc, LAT);
        compare_frames("a5");
        check("a5_frm", frm_obs, 0);

        // Back-to-back, no idle gap.
        send_good(8'h00);
        send_good(8'hFF);
        send_good(8'h55);
        #(BIT_NS + $urandom_range(0, 3000));
        compare_frames("b2b");
        check("b2b_frm", frm_obs, 0);

        // Short low glitch is rejected as a false start.
        rxd_i = 1'b0;
        #4000;
        rxd_i = 1'b1;
        #(2 * BIT_NS);
        compare_frames("glitch");
        check("glitch_hold", {24'h0, rx_data}, {24'h0, last_good});

        // Bad STOP followed by a held break, then a good frame.
        send_frame(8'h3C, 1'b0, even_par(8'h3C));
        #(BIT_NS);
        check("brk_frm_first", frm_obs, 1);
        #100000;
        check("brk_frm_held", frm_obs, 1);
        compare_frames("brk_nostrobe");
        check("brk_data_hold", {24'h0, rx_data}, {24'h0, last_good});
        rxd_i = 1'b1;
        #(2 * BIT_NS);
        send_good(8'h12);
        #(BIT_NS);
        compare_frames("after_brk");
        check("after_brk_frm", frm_obs, 1);

        // Reset in the middle of data bit 4 of 0x81.
        rxd_i = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rxd_i = (i == 0) ? 1'b1 : 1'b0;
            #(BIT_NS);
        end
        rxd_i = 1'b0;
        #(BIT_NS / 2);
        rst_clk_rx = 1'b0;
        #1;
        check("mid_rst_data", {24'h0, rx_data}, 32'h0);
        check("mid_rst_rdy", {31'h0, rx_data_rdy}, 32'h0);
        check("mid_rst_frm", {31'h0, frm_err}, 32'h0);
        rxd_i = 1'b1;
        #200;
        rst_clk_rx = 1'b1;
        #(2 * BIT_NS);
        compare_frames("mid_rst_nostrobe");
        check("mid_rst_frm_cnt", frm_obs, 1);
        last_good = 8'h00;
        send_good(8'h81);
        #(BIT_NS);
        compare_frames("after_rst");

`ifdef UART_RX_PARITY_EN
        // Wrong parity still delivers data, with par_err on the strobe.
        exp_q.push_back('{data: 8'h07, perr: 1'b1});
        send_frame(8'h07, 1'b1, 1'b0);
        #(BIT_NS);
        compare_frames("par_bad");
`else
        rnd = 8'($urandom_range(0, 255));
        #($urandom_range(1000, 5000));
        send_good(rnd);
        #(BIT_NS);
        compare_frames("random");
`endif

        check("rdy_frm_overlap", overlap, 0);
        check("stray_perr", stray_perr, 0);
        check("final_frm", frm_obs, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
